// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline.
// Produces the stall, flush and bubble controls for the pipeline registers.
// Hazards are handled in this priority order: a DCache miss freezes the whole
// pipe, then a divide in EX holds the front end, then a taken branch flushes,
// and finally a load-use hazard inserts a single bubble.
module pipe_hazard_ctrl #(
    parameter int DIV_LAT     = 8,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [4:0]             id_rj,
    input  logic [4:0]             id_rk,
    input  logic                   id_rj_re,
    input  logic                   id_rk_re,
    input  logic                   ex_valid,
    input  logic [4:0]             ex_rd,
    input  logic                   ex_is_load,
    input  logic                   ex_is_div,
    input  logic                   ex_br_taken,
    input  logic                   dc_busy,
    output logic                   pc_stall,
    output logic                   if_id_stall,
    output logic                   if_id_flush,
    output logic                   id_ex_stall,
    output logic                   id_ex_flush_branch,
    output logic                   id_ex_flush_load,
    output logic                   ex_mem_stall,
    output logic                   ex_mem_bubble,
    output logic                   div_busy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int DCNT_W = $clog2(DIV_LAT + 1);

    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] DIV_WAIT = 1'b1;

    localparam logic [DCNT_W-1:0]      DCNT_ONE  = 1;
    localparam logic [DCNT_W-1:0]      DCNT_INIT = DCNT_W'(DIV_LAT - 1);
    localparam logic [STALL_CNT_W-1:0] CNT_ONE   = 1;

    logic [0:0]             state, state_nxt;
    logic [DCNT_W-1:0]      dcnt, dcnt_nxt;
    logic [STALL_CNT_W-1:0] cnt_q;

    logic freeze;
    logic div_start;
    logic div_hold;
    logic branch;
    logic src_hit;
    logic loaduse;

    // Hazard classification in priority order: freeze > div_hold > branch > loaduse.
    always_comb begin
        freeze    = dc_busy;
        div_start = (state == RUN) && ex_valid && ex_is_div;
        div_hold  = !freeze && (div_start || ((state == DIV_WAIT) && (dcnt != '0)));
        branch    = !freeze && !div_hold && ex_valid && ex_br_taken;
        src_hit   = (id_rj_re && (id_rj == ex_rd)) || (id_rk_re && (id_rk == ex_rd));
        loaduse   = !freeze && !div_hold && !branch && ex_valid && ex_is_load &&
                    (ex_rd != 5'd0) && id_valid && src_hit;
    end

    // Pipeline controls, all held low while reset is asserted.
    always_comb begin
        pc_stall           = !rst && (freeze || div_hold || loaduse);
        if_id_stall        = !rst && (freeze || div_hold || loaduse);
        id_ex_stall        = !rst && (freeze || div_hold);
        ex_mem_stall       = !rst && freeze;
        ex_mem_bubble      = !rst && div_hold;
        if_id_flush        = !rst && branch;
        id_ex_flush_branch = !rst && branch;
        id_ex_flush_load   = !rst && loaduse;
        div_busy           = !rst && (state == DIV_WAIT);
        stall_cnt          = rst ? '0 : cnt_q;
    end

    // Divide sequencing: the entry cycle in RUN is the first stall cycle,
    // DIV_WAIT then supplies DIV_LAT-1 more and releases when dcnt reaches 0.
    always_comb begin
        state_nxt = state;
        dcnt_nxt  = dcnt;
        if (!freeze) begin
            case (state)
                RUN: begin
                    if (ex_valid && ex_is_div) begin
                        state_nxt = DIV_WAIT;
                        dcnt_nxt  = DCNT_INIT;
                    end
                end
                DIV_WAIT: begin
                    if (dcnt != '0) begin
                        dcnt_nxt = dcnt - DCNT_ONE;
                    end else begin
                        state_nxt = RUN;
                    end
                end
                default: begin
                    state_nxt = RUN;
                    dcnt_nxt  = '0;
                end
            endcase
        end
    end

    // State registers and the free-running PC-stall cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            dcnt  <= '0;
            cnt_q <= '0;
        end else begin
            state <= state_nxt;
            dcnt  <= dcnt_nxt;
            if (pc_stall) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// behavioural model that tracks divide stall cycles served.
module tb_pipe_hazard_ctrl;

    localparam int DIV_LAT = 8;
    localparam int SCW     = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic id_valid = 1'b0;
    logic [4:0] id_rj = '0;
    logic [4:0] id_rk = '0;
    logic id_rj_re = 1'b0;
    logic id_rk_re = 1'b0;
    logic ex_valid = 1'b0;
    logic [4:0] ex_rd = '0;
    logic ex_is_load = 1'b0;
    logic ex_is_div = 1'b0;
    logic ex_br_taken = 1'b0;
    logic dc_busy = 1'b0;

    logic pc_stall, if_id_stall, if_id_flush, id_ex_stall;
    logic id_ex_flush_branch, id_ex_flush_load, ex_mem_stall, ex_mem_bubble, div_busy;
    logic [SCW-1:0] stall_cnt;

    int vectors = 0;
    int miscompares = 0;

    pipe_hazard_ctrl #(.DIV_LAT(DIV_LAT), .STALL_CNT_W(SCW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rj(id_rj), .id_rk(id_rk),
        .id_rj_re(id_rj_re), .id_rk_re(id_rk_re), .ex_valid(ex_valid), .ex_rd(ex_rd),
        .ex_is_load(ex_is_load), .ex_is_div(ex_is_div), .ex_br_taken(ex_br_taken),
        .dc_busy(dc_busy), .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .if_id_flush(if_id_flush), .id_ex_stall(id_ex_stall),
        .id_ex_flush_branch(id_ex_flush_branch), .id_ex_flush_load(id_ex_flush_load),
        .ex_mem_stall(ex_mem_stall), .ex_mem_bubble(ex_mem_bubble),
        .div_busy(div_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Model: a divide owes DIV_LAT stall cycles; it is "active" once the first
    // has been paid and stays active for one release cycle after the last.
    bit m_active = 1'b0;
    int m_served = 0;
    int m_cnt    = 0;

    // {pc, if_id_stall, if_id_flush, id_ex_stall, flush_br, flush_ld, ex_mem_stall, bubble, busy}
    function automatic logic [8:0] model_out();
        bit frz, hold, br, lu, stall;
        if (rst) return '0;
        frz  = dc_busy;
        hold = !frz && ((!m_active && ex_valid && ex_is_div) ||
                        (m_active && m_served < DIV_LAT));
        br   = !frz && !hold && ex_valid && ex_br_taken;
        lu   = !frz && !hold && !br && ex_valid && ex_is_load && ex_rd != 0 && id_valid &&
               ((id_rj_re && id_rj == ex_rd) || (id_rk_re && id_rk == ex_rd));
        stall = frz || hold || lu;
        return {stall, stall, br, frz || hold, br, lu, frz, hold, m_active};
    endfunction

    always @(posedge clk) begin
        logic [8:0] o;
        o = model_out();
        if (rst) begin
            m_active = 1'b0;
            m_served = 0;
            m_cnt    = 0;
        end else begin
            if (o[8]) m_cnt = (m_cnt + 1) % (1 << SCW);
            if (!dc_busy) begin
                if (o[1]) begin
                    m_served = m_served + 1;
                    m_active = 1'b1;
                end else if (m_active) begin
                    m_active = 1'b0;
                    m_served = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [8:0] e, a;
        logic [SCW-1:0] ec;
        e  = model_out();
        a  = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush_branch,
              id_ex_flush_load, ex_mem_stall, ex_mem_bubble, div_busy};
        ec = rst ? '0 : SCW'(m_cnt);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL outputs @%0t: got %b expected %b", $time, a, e);
        end
        vectors++;
        if (stall_cnt !== ec) begin
            miscompares++;
            $display("FAIL stall_cnt @%0t: got %0d expected %0d", $time, stall_cnt, ec);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rj = 0; id_rk = 0; id_rj_re = 0; id_rk_re = 0;
        ex_valid = 0; ex_rd = 0; ex_is_load = 0; ex_is_div = 0; ex_br_taken = 0;
        dc_busy = 0;
    endtask

    task automatic load_use(input logic [4:0] rd, input logic [4:0] rj, input logic rj_re,
                            input logic [4:0] rk, input logic rk_re);
        idle();
        ex_valid = 1; ex_is_load = 1; ex_rd = rd;
        id_valid = 1; id_rj = rj; id_rj_re = rj_re; id_rk = rk; id_rk_re = rk_re;
    endtask

    initial begin
        int stalls;
        idle();
        rst = 1;
        nxt(); nxt();
        @(negedge clk);
        chk("reset_pc_stall", pc_stall, 0);
        chk("reset_stall_cnt", stall_cnt, 0);
        chk("reset_div_busy", div_busy, 0);
        nxt();
        rst = 0;

        // Load-use on rj
        load_use(5, 5, 1, 0, 0);
        @(negedge clk);
        chk("lu_pc_stall", pc_stall, 1);
        chk("lu_if_id_stall", if_id_stall, 1);
        chk("lu_flush_load", id_ex_flush_load, 1);
        nxt(); idle();
        @(negedge clk);
        chk("lu_after_pc_stall", pc_stall, 0);
        chk("lu_after_flush_load", id_ex_flush_load, 0);
        chk("lu_after_cnt", stall_cnt, 1);
        nxt();

        // r0 and non-reading sources never stall; rk match does
        load_use(0, 0, 1, 0, 1);
        @(negedge clk); chk("lu_r0", pc_stall, 0); nxt();
        load_use(5, 5, 0, 7, 1);
        @(negedge clk); chk("lu_rj_re0", pc_stall, 0); nxt();
        load_use(9, 1, 1, 9, 1);
        @(negedge clk); chk("lu_rk", id_ex_flush_load, 1); nxt();

        // Taken branch
        idle(); ex_valid = 1; ex_br_taken = 1;
        @(negedge clk);
        chk("br_if_id_flush", if_id_flush, 1);
        chk("br_id_ex_flush", id_ex_flush_branch, 1);
        chk("br_pc_stall", pc_stall, 0);
        nxt(); idle();
        @(negedge clk); chk("br_cnt", stall_cnt, 2); nxt();

        // Plain divide: 8 stall cycles, busy cycles 2..9
        stalls = 0;
        for (int c = 1; c <= 10; c++) begin
            idle();
            if (c <= 9) begin ex_valid = 1; ex_is_div = 1; end
            @(negedge clk);
            if (pc_stall && ex_mem_bubble && !ex_mem_stall) stalls++;
            if (c == 1) chk("div_c1_busy", div_busy, 0);
            if (c == 2) chk("div_c2_busy", div_busy, 1);
            if (c == 9) begin chk("div_c9_busy", div_busy, 1); chk("div_c9_stall", pc_stall, 0); end
            if (c == 10) chk("div_c10_busy", div_busy, 0);
            nxt();
        end
        chk("div_stall_cycles", stalls, 8);

        // Divide with a 3-cycle freeze starting at cycle 4
        stalls = 0;
        for (int c = 1; c <= 12; c++) begin
            idle();
            ex_valid = 1; ex_is_div = 1;
            dc_busy = (c >= 4 && c <= 6);
            @(negedge clk);
            if (pc_stall) stalls++;
            if (c == 5) begin chk("divfrz_ems", ex_mem_stall, 1); chk("divfrz_bub", ex_mem_bubble, 0); end
            if (c == 12) begin chk("divfrz_rel_stall", pc_stall, 0); chk("divfrz_rel_busy", div_busy, 1); end
            nxt();
        end
        chk("divfrz_stall_cycles", stalls, 11);
        idle(); nxt();

        // Branch held under freeze
        idle(); ex_valid = 1; ex_br_taken = 1; dc_busy = 1;
        @(negedge clk); chk("brfrz_flush", if_id_flush, 0); nxt();
        @(negedge clk); chk("brfrz_flush2", id_ex_flush_branch, 0); nxt();
        dc_busy = 0;
        @(negedge clk); chk("brfrz_release", if_id_flush, 1); nxt();

        // Reset during a divide
        idle(); ex_valid = 1; ex_is_div = 1;
        nxt(); nxt();
        rst = 1;
        @(negedge clk);
        chk("rstdiv_pc_stall", pc_stall, 0);
        chk("rstdiv_busy", div_busy, 0);
        nxt();
        rst = 0; idle();
        @(negedge clk);
        chk("rstdiv_after_busy", div_busy, 0);
        chk("rstdiv_after_cnt", stall_cnt, 0);
        chk("rstdiv_after_stall", pc_stall, 0);
        nxt();

        // 17 stall cycles wrap a 4-bit counter to 1
        dc_busy = 1;
        repeat (17) nxt();
        idle();
        @(negedge clk); chk("cnt_wrap", stall_cnt, 1); nxt();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 199) == 0);
            dc_busy     = ($urandom_range(0, 9) == 0);
            ex_valid    = ($urandom_range(0, 3) != 0);
            ex_is_div   = ($urandom_range(0, 19) == 0);
            ex_is_load  = ($urandom_range(0, 2) == 0);
            ex_br_taken = ($urandom_range(0, 7) == 0);
            ex_rd       = 5'($urandom_range(0, 3));
            id_valid    = ($urandom_range(0, 3) != 0);
            id_rj       = 5'($urandom_range(0, 3));
            id_rk       = 5'($urandom_range(0, 3));
            id_rj_re    = 1'($urandom_range(0, 1));
            id_rk_re    = 1'($urandom_range(0, 1));
            nxt();
        end
        rst = 0; idle();
        repeat (12) nxt();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
